checkpoint_seq_monitor: RTL and testbench
=========================================

Name: checkpoint_seq_monitor

Overview:
- Synthesizable, parametrised checkpoint monitor for the GPIO checkbits field (mprj_io[31:16] in the counter_la bench).
- Holds a programmable table of expected codes and tracks them in order, with debounce, per-step timeout and optional strict-order checking.
- Reports pass/fail status and failure cause.
- Usable in RTL/GL benches and as an on-FPGA self-check. The harness drives mon_in from the pad field.

Parameters:
WIDTH, 16, width of monitored code
NUM_CKPT, 8, expected-code table depth (>=1)
TIMEOUT_W, 32, width of timeout limit and cycle counter
STABLE_CYCLES, 2, consecutive equal synchronized samples required to qualify a value (>=1)

Ports:
clock  in  1  system clock
resetb  in  1  asynchronous active-low reset
mon_in  in  WIDTH  monitored code (asynchronous to clock)
load_en  in  1  write ckpt table entry this cycle
load_idx  in  $clog2(NUM_CKPT)  table index
load_val  in  WIDTH  expected code
num_active  in  $clog2(NUM_CKPT)+1  checkpoints in use, sampled at start
timeout_limit  in  TIMEOUT_W  max cycles between hits; 0 = disabled; sampled at start
strict  in  1  enable out-of-order detection; sampled at start
start  in  1  arm monitor
abort  in  1  return to IDLE
busy  out  1  high in ARMED
pass  out  1  sticky pass
fail  out  1  sticky fail
fail_code  out  2  00 none, 01 timeout, 10 order
ckpt_idx  out  $clog2(NUM_CKPT)+1  index of next expected checkpoint
hit_pulse  out  1  one-cycle pulse per matched checkpoint
step_cycles  out  TIMEOUT_W  cycles since arm or last hit

Behaviour:
- Reset (async, resetb=0): all outputs 0; table entries 0; state IDLE; sync/debounce registers 0.
- Input path:
  - Two-flop synchronizer s1->s2.
  - Debounce register last/cnt: if s2!=last then last<=s2, cnt<=1; else if cnt<STABLE_CYCLES then cnt++.
  - qual fires for one cycle when cnt becomes STABLE_CYCLES.
  - Each stable value therefore qualifies exactly once. A repeated expected code must change and return before it can match again.
- Latency: hit_pulse registered high STABLE_CYCLES+2 clocks after the first edge sampling the new mon_in value.
- Table writes: accepted only when state != ARMED; ignored while busy.
- States:
  - IDLE: outputs pass/fail 0. start -> ARMED. Latch num_active clamped to NUM_CKPT, timeout_limit and strict. Clear ckpt_idx, step_cycles, fail_code.
  - ARMED:
    - step_cycles increments each cycle, saturating at all-ones.
    - qual with last==table[ckpt_idx] -> hit_pulse=1, ckpt_idx++, step_cycles<=0. If that was entry num_active-1 -> PASS.
    - strict=1 and qual with last==table[j] for some j in (ckpt_idx, num_active) and last!=table[ckpt_idx] -> FAIL, fail_code=10.
    - Non-matching qual values are ignored otherwise.
    - timeout_limit!=0 and step_cycles==timeout_limit-1 with no hit this cycle -> FAIL, fail_code=01.
    - Hit and timeout in the same cycle: hit wins.
  - Empty table: start with num_active==0 -> PASS on the next cycle, no hit_pulse.
  - PASS: pass=1, busy=0. Holds until start (re-arm, pass cleared) or abort.
  - FAIL: fail=1, busy=0. ckpt_idx frozen at the failing step. Holds until start or abort.
  - abort: any state -> IDLE next cycle. Has priority over start and hits. Table is retained.
  - start while ARMED: ignored.
- The synchronizer and debouncer run in all states. A value already stable at arm time does not qualify until it changes.

Test Plan:
1. Table {AB40,003E,0044,004A,0050,AB51}, num_active=6, timeout 0. Drive the codes in order, each held 10 cycles -> six hit_pulses, each STABLE_CYCLES+2 clocks after its change; pass=1, ckpt_idx=6.
2. Same table, timeout_limit=100. Hold 0044 with no further change -> fail=1, fail_code=01 exactly 100 cycles after the 0044 hit; ckpt_idx=3.
3. strict=1, table as in 1. Drive AB40 then 0044 -> fail, fail_code=10, ckpt_idx=1. Repeat with strict=0 -> 0044 ignored; the 003E,0044,... sequence then passes.
4. Glitch: 1-cycle pulse of 003E between stable AB40 values with STABLE_CYCLES=2 -> no hit. Table {1111,1111}: hold 1111 -> one hit only. Change to 0000 then back to 1111 -> second hit, pass.
5. Timeout_limit=20 with the hit qualifying on the cycle the timeout would fire -> hit wins, no fail. abort mid-ARMED -> IDLE, busy=0, table intact. Reset mid-ARMED -> all outputs 0, table cleared.
6. num_active=0 -> pass one cycle after start. num_active=15 with NUM_CKPT=8 -> clamped to 8. load_en while busy -> table unchanged.

Source files
------------

// File: rtl/checkpoint_seq_monitor.sv
// Purpose : ordered checkpoint monitor for a GPIO code field; matches debounced codes against a table.
// Latency : hit_pulse rises STABLE_CYCLES+2 clocks after the first edge that samples a new mon_in value.
// Backpr. : none; the block only observes mon_in, and table writes are dropped while armed.
//
// Ports: clock/resetb (async active-low); mon_in async code input; load_en/load_idx/load_val table
// write port; num_active/timeout_limit/strict latched on start; start/abort control;
// busy/pass/fail/fail_code status; ckpt_idx next expected entry; hit_pulse per match;
// step_cycles cycles since arm or last hit.
module checkpoint_seq_monitor #(
    parameter int WIDTH         = 16,
    parameter int NUM_CKPT      = 8,
    parameter int TIMEOUT_W     = 32,
    parameter int STABLE_CYCLES = 2,
    localparam int IDX_W        = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int CNT_W        = $clog2(NUM_CKPT) + 1
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic [WIDTH-1:0]     mon_in,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [CNT_W-1:0]     num_active,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 strict,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [CNT_W-1:0]     ckpt_idx,
    output logic                 hit_pulse,
    output logic [TIMEOUT_W-1:0] step_cycles
);

    localparam int DC_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     sync1, sync2, last_val;
    logic [DC_W-1:0]      stab_cnt;
    logic                 qual;
    logic [WIDTH-1:0]     ckpt_tbl [NUM_CKPT];
    logic [CNT_W-1:0]     n_act;
    logic [TIMEOUT_W-1:0] tlim_r;
    logic                 strict_r;

    logic                 do_arm, do_hit, fail_to, fail_ord;
    logic                 match_cur, order_err, tmo_hit;
    logic [CNT_W-1:0]     num_clamped;
    logic [WIDTH-1:0]     cur_code;

    // Synchronizer and debouncer run in every state. qual is high for exactly one
    // cycle, the one after the run of equal samples reaches STABLE_CYCLES, so a
    // held value can only ever match once.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1    <= '0;
            sync2    <= '0;
            last_val <= '0;
            stab_cnt <= '0;
            qual     <= 1'b0;
        end else begin
            sync1 <= mon_in;
            sync2 <= sync1;
            if (sync2 != last_val) begin
                last_val <= sync2;
                stab_cnt <= DC_W'(1);
                qual     <= (STABLE_CYCLES == 1);
            end else begin
                qual <= (stab_cnt == DC_W'(STABLE_CYCLES - 1));
                if (stab_cnt < DC_W'(STABLE_CYCLES))
                    stab_cnt <= stab_cnt + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_CKPT; i++)
                ckpt_tbl[i] <= '0;
        end else if (load_en && state != S_ARMED && int'(load_idx) < NUM_CKPT) begin
            ckpt_tbl[load_idx] <= load_val;
        end
    end

    assign num_clamped = (num_active > CNT_W'(NUM_CKPT)) ? CNT_W'(NUM_CKPT) : num_active;
    // Only consulted while armed, where ckpt_idx < n_act <= NUM_CKPT.
    assign cur_code    = ckpt_tbl[ckpt_idx[IDX_W-1:0]];
    assign match_cur   = qual && (last_val == cur_code);
    assign tmo_hit     = (tlim_r != '0) && (step_cycles == tlim_r - TIMEOUT_W'(1));

    // A qualified code that belongs to a later, still-pending entry means a step was skipped.
    always_comb begin
        order_err = 1'b0;
        for (int j = 0; j < NUM_CKPT; j++) begin
            if (CNT_W'(j) > ckpt_idx && CNT_W'(j) < n_act && ckpt_tbl[j] == last_val)
                order_err = 1'b1;
        end
        order_err = order_err && strict_r && qual;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Priority inside ARMED: abort > empty table > hit > order error > timeout.
    always_comb begin
        state_nxt = state;
        do_arm    = 1'b0;
        do_hit    = 1'b0;
        fail_to   = 1'b0;
        fail_ord  = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_ARMED: begin
                    if (n_act == '0) begin
                        state_nxt = S_PASS;
                    end else if (match_cur) begin
                        do_hit = 1'b1;
                        if (ckpt_idx == n_act - CNT_W'(1))
                            state_nxt = S_PASS;
                    end else if (order_err) begin
                        fail_ord  = 1'b1;
                        state_nxt = S_FAIL;
                    end else if (tmo_hit) begin
                        fail_to   = 1'b1;
                        state_nxt = S_FAIL;
                    end
                end
                default: begin
                    if (start) begin
                        do_arm    = 1'b1;
                        state_nxt = S_ARMED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            n_act       <= '0;
            tlim_r      <= '0;
            strict_r    <= 1'b0;
            ckpt_idx    <= '0;
            step_cycles <= '0;
            fail_code   <= 2'b00;
            hit_pulse   <= 1'b0;
        end else begin
            hit_pulse <= do_hit;
            if (abort) begin
                fail_code <= 2'b00;
            end else if (do_arm) begin
                n_act       <= num_clamped;
                tlim_r      <= timeout_limit;
                strict_r    <= strict;
                ckpt_idx    <= '0;
                step_cycles <= '0;
                fail_code   <= 2'b00;
            end else if (state == S_ARMED) begin
                if (do_hit) begin
                    ckpt_idx    <= ckpt_idx + CNT_W'(1);
                    step_cycles <= '0;
                end else if (step_cycles != '1) begin
                    step_cycles <= step_cycles + TIMEOUT_W'(1);
                end
                if (fail_ord)     fail_code <= 2'b10;
                else if (fail_to) fail_code <= 2'b01;
            end
        end
    end

    assign busy = (state == S_ARMED);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Purpose : directed bench for checkpoint_seq_monitor with a cycle-level reference model.
// Latency : model outputs valid after each clock edge; compared 1 time unit after the edge.
// Backpr. : none.
module tb_checkpoint_seq_monitor;

    localparam int ST = 2;

    logic        clock;
    logic        resetb;
    logic [15:0] mon_in;
    logic        load_en;
    logic [2:0]  load_idx;
    logic [15:0] load_val;
    logic [3:0]  num_active;
    logic [31:0] timeout_limit;
    logic        strict;
    logic        start;
    logic        abort;
    logic        busy, pass, fail, hit_pulse;
    logic [1:0]  fail_code;
    logic [3:0]  ckpt_idx;
    logic [31:0] step_cycles;

    int n_cmp = 0;
    int n_err = 0;

    checkpoint_seq_monitor #(
        .WIDTH(16), .NUM_CKPT(8), .TIMEOUT_W(32), .STABLE_CYCLES(ST)
    ) dut (
        .clock(clock), .resetb(resetb), .mon_in(mon_in),
        .load_en(load_en), .load_idx(load_idx), .load_val(load_val),
        .num_active(num_active), .timeout_limit(timeout_limit), .strict(strict),
        .start(start), .abort(abort),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .ckpt_idx(ckpt_idx), .hit_pulse(hit_pulse), .step_cycles(step_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A code qualifies when, seen through the 2-cycle synchronizer, it has been
    // sampled ST times in a row right after a different value.
    int          m_state;   // 0 idle, 1 armed, 2 pass, 3 fail
    logic [15:0] m_tbl [8];
    int          m_n, m_idx;
    logic [31:0] m_tlim, m_step;
    bit          m_strict, m_hit, m_q;
    logic [1:0]  m_fc;
    logic [15:0] m_qv;
    logic [15:0] hist [ST+3];

    always @(posedge clock) begin
        if (!resetb) begin
            m_state = 0; m_n = 0; m_idx = 0; m_tlim = 0; m_step = 0;
            m_strict = 0; m_hit = 0; m_q = 0; m_fc = 0; m_qv = 0;
            for (int i = 0; i < 8; i++) m_tbl[i] = 16'h0;
            for (int i = 0; i < ST + 3; i++) hist[i] = 16'h0;
        end else begin
            int pre;
            bit order;
            pre   = m_state;
            m_hit = 0;
            order = 0;
            if (abort) begin
                m_state = 0;
                m_fc    = 0;
            end else if (m_state == 1) begin
                if (m_n == 0) begin
                    m_state = 2;
                end else if (m_q && m_qv == m_tbl[m_idx]) begin
                    m_hit = 1;
                    m_idx++;
                    if (m_idx == m_n) m_state = 2;
                end else begin
                    if (m_strict && m_q)
                        for (int j = m_idx + 1; j < m_n; j++)
                            if (m_tbl[j] == m_qv) order = 1;
                    if (order) begin
                        m_state = 3; m_fc = 2'b10;
                    end else if (m_tlim != 0 && m_step == m_tlim - 1) begin
                        m_state = 3; m_fc = 2'b01;
                    end
                end
                if (m_hit) m_step = 0;
                else if (m_step != 32'hFFFF_FFFF) m_step++;
            end else if (start) begin
                m_state  = 1;
                m_n      = (int'(num_active) > 8) ? 8 : int'(num_active);
                m_tlim   = timeout_limit;
                m_strict = strict;
                m_idx    = 0;
                m_step   = 0;
                m_fc     = 0;
            end
            if (pre != 1 && load_en) m_tbl[load_idx] = load_val;
            for (int i = ST + 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = mon_in;
            m_q = (hist[ST+2] != hist[2]);
            for (int i = 3; i <= ST + 1; i++)
                if (hist[i] != hist[2]) m_q = 0;
            m_qv = hist[2];
        end
    end

    always @(posedge clock) begin
        #1;
        if (resetb) begin
            chk("cyc_busy", 32'(busy), 32'(m_state == 1));
            chk("cyc_pass", 32'(pass), 32'(m_state == 2));
            chk("cyc_fail", 32'(fail), 32'(m_state == 3));
            chk("cyc_fail_code", 32'(fail_code), 32'(m_fc));
            chk("cyc_ckpt_idx", 32'(ckpt_idx), 32'(m_idx));
            chk("cyc_hit_pulse", 32'(hit_pulse), 32'(m_hit));
            chk("cyc_step_cycles", step_cycles, m_step);
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input int idx, input logic [15:0] v);
        @(negedge clock);
        load_en = 1'b1; load_idx = 3'(idx); load_val = v;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic arm(input int na, input logic [31:0] tl, input logic st);
        @(negedge clock);
        num_active = 4'(na); timeout_limit = tl; strict = st; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    // Drive v, observe ncyc edges; first_hit is the edge index (0 = first sampling edge).
    task automatic drive_hold(input logic [15:0] v, input int ncyc, output int first_hit, output int nhits);
        @(negedge clock);
        mon_in = v; first_hit = -1; nhits = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clock); #1;
            if (hit_pulse) begin
                if (first_hit < 0) first_hit = k;
                nhits++;
            end
        end
    endtask

    logic [15:0] seq1 [6] = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51};

    initial begin
        int fh, nh, tot, hit_k, fail_k;
        resetb = 1'b0; mon_in = 16'h5555; load_en = 1'b0; load_idx = 3'd0; load_val = 16'h0;
        num_active = 4'd0; timeout_limit = 32'd0; strict = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_step", step_cycles, 32'd0);
        resetb = 1'b1;
        repeat (6) @(negedge clock);

        // 1: in-order sequence, latency of each hit
        for (int i = 0; i < 6; i++) load(i, seq1[i]);
        arm(6, 0, 1'b0);
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            drive_hold(seq1[i], 10, fh, nh);
            chk($sformatf("t1_lat_%0d", i), 32'(fh), 32'd4);
            tot += nh;
        end
        chk("t1_hits", 32'(tot), 32'd6);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_idx", 32'(ckpt_idx), 32'd6);

        // 2: timeout 100 cycles after the third hit
        arm(6, 100, 1'b0);
        drive_hold(16'hAB40, 10, fh, nh);
        drive_hold(16'h003E, 10, fh, nh);
        @(negedge clock);
        mon_in = 16'h0044; hit_k = -1; fail_k = -1;
        for (int k = 0; k < 200 && fail_k < 0; k++) begin
            @(posedge clock); #1;
            if (hit_pulse && hit_k < 0) hit_k = k;
            if (fail && fail_k < 0) fail_k = k;
        end
        chk("t2_hit_lat", 32'(hit_k), 32'd4);
        chk("t2_tmo_dist", 32'(fail_k - hit_k), 32'd100);
        chk("t2_code", 32'(fail_code), 32'd1);
        chk("t2_idx", 32'(ckpt_idx), 32'd3);

        // 3: strict order error, then same pattern non-strict passes
        arm(6, 0, 1'b1);
        drive_hold(16'hAB40, 10, fh, nh);
        drive_hold(16'h0044, 10, fh, nh);
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_code", 32'(fail_code), 32'd2);
        chk("t3_idx", 32'(ckpt_idx), 32'd1);
        arm(6, 0, 1'b0);
        drive_hold(16'hAB40, 10, fh, nh);
        drive_hold(16'h0044, 10, fh, nh);
        chk("t3_ignored", 32'(nh), 32'd0);
        for (int i = 1; i < 6; i++) drive_hold(seq1[i], 10, fh, nh);
        chk("t3_pass", 32'(pass), 32'd1);

        // 4: glitch rejected; repeated code needs a change in between
        arm(6, 0, 1'b0);
        drive_hold(16'hAB40, 10, fh, nh);
        drive_hold(16'h003E, 1, fh, nh);
        tot = nh;
        drive_hold(16'hAB40, 12, fh, nh);
        chk("t4_glitch", 32'(tot + nh), 32'd0);
        chk("t4_glitch_idx", 32'(ckpt_idx), 32'd1);
        do_abort();
        load(0, 16'h1111);
        load(1, 16'h1111);
        arm(2, 0, 1'b0);
        drive_hold(16'h1111, 30, fh, nh);
        chk("t4_rep_once", 32'(nh), 32'd1);
        drive_hold(16'h0000, 10, fh, nh);
        drive_hold(16'h1111, 10, fh, nh);
        chk("t4_rep_second", 32'(nh), 32'd1);
        chk("t4_rep_pass", 32'(pass), 32'd1);

        // 5: hit coincident with timeout wins; abort keeps table; reset clears it
        load(0, 16'h0A0A);
        load(1, 16'h0B0B);
        arm(2, 20, 1'b0);
        repeat (15) @(posedge clock);
        drive_hold(16'h0A0A, 10, fh, nh);
        chk("t5_hit_lat", 32'(fh), 32'd4);
        chk("t5_no_fail", 32'(fail), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        do_abort();
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_pass", 32'(pass), 32'd0);
        arm(2, 0, 1'b0);
        drive_hold(16'h0000, 10, fh, nh);
        drive_hold(16'h0A0A, 10, fh, nh);
        drive_hold(16'h0B0B, 10, fh, nh);
        chk("t5_table_kept", 32'(pass), 32'd1);
        arm(2, 0, 1'b0);
        drive_hold(16'h0A0A, 10, fh, nh);
        chk("t5_pre_rst_idx", 32'(ckpt_idx), 32'd1);
        @(negedge clock);
        resetb = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_idx", 32'(ckpt_idx), 32'd0);
        chk("t5_rst_step", step_cycles, 32'd0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (5) @(negedge clock);
        arm(2, 0, 1'b0);
        drive_hold(16'h5555, 10, fh, nh);
        drive_hold(16'h0000, 10, fh, nh);
        chk("t5_tbl_zero_hit", 32'(nh), 32'd1);
        chk("t5_tbl_zero_idx", 32'(ckpt_idx), 32'd1);
        do_abort();

        // 6: empty table, clamped count, writes blocked while busy
        arm(0, 0, 1'b0);
        chk("t6_empty_busy", 32'(busy), 32'd1);
        chk("t6_empty_nopass", 32'(pass), 32'd0);
        @(posedge clock); #1;
        chk("t6_empty_pass", 32'(pass), 32'd1);
        chk("t6_empty_nohit", 32'(hit_pulse), 32'd0);
        for (int i = 0; i < 8; i++) load(i, 16'h0100 + 16'(i));
        arm(15, 0, 1'b0);
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            drive_hold(16'h0100 + 16'(i), 8, fh, nh);
            tot += nh;
        end
        chk("t6_clamp_hits", 32'(tot), 32'd8);
        chk("t6_clamp_pass", 32'(pass), 32'd1);
        chk("t6_clamp_idx", 32'(ckpt_idx), 32'd8);
        arm(8, 0, 1'b0);
        load(0, 16'hFFFF);
        drive_hold(16'h0100, 10, fh, nh);
        chk("t6_busy_write", 32'(nh), 32'd1);
        do_abort();
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
